// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART time sender
package uart_pkg;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] COLON   = 8'h3A;
  localparam logic [7:0] DOT     = 8'h2E;
  localparam logic [7:0] CR      = 8'h0D;
  localparam logic [7:0] LF      = 8'h0A;

  localparam int MSG_LEN_FULL  = 13;
  localparam int MSG_LEN_SHORT = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Map a single decimal digit (0-9) onto its ASCII character.
  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2ascii2.sv
// rtl/bin2ascii2.sv - 7-bit binary to two ASCII decimal digits, saturating at 99
module bin2ascii2
  import uart_pkg::*;
(
  input  logic [6:0] value,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [3:0] tens_d;
  logic [3:0] ones_d;

  // Split into decimal digits; anything above 99 is shown as "99".
  always_comb begin
    tens_d = 4'd9;
    ones_d = 4'd9;
    if (value <= 7'd99) begin
      tens_d = 4'(value / 7'd10);
      ones_d = 4'(value % 7'd10);
    end
    tens = digit_char(tens_d);
    ones = digit_char(ones_d);
  end

endmodule

// File: rtl/uart_time_sender.sv
// rtl/uart_time_sender.sv - formats a time snapshot as ASCII and feeds it to uart_tx
module uart_time_sender
  import uart_pkg::*;
#(
  parameter bit LINE_END = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_csec,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam int         MSG_LEN  = LINE_END ? MSG_LEN_FULL : MSG_LEN_SHORT;
  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] idx;

  logic [4:0] snap_hour;
  logic [5:0] snap_min;
  logic [5:0] snap_sec;
  logic [6:0] snap_csec;

  logic       busy_q;
  logic       done_q;

  logic       load;
  logic       advance;
  logic       finish;
  logic       start_c;

  logic [7:0] hour_t, hour_o;
  logic [7:0] min_t,  min_o;
  logic [7:0] sec_t,  sec_o;
  logic [7:0] csec_t, csec_o;
  logic [7:0] char_mux;

  // Digits are derived only from the snapshot, so input changes mid-message never leak in.
  bin2ascii2 u_hour (.value({2'b00, snap_hour}), .tens(hour_t), .ones(hour_o));
  bin2ascii2 u_min  (.value({1'b0, snap_min}),   .tens(min_t),  .ones(min_o));
  bin2ascii2 u_sec  (.value({1'b0, snap_sec}),   .tens(sec_t),  .ones(sec_o));
  bin2ascii2 u_csec (.value(snap_csec),          .tens(csec_t), .ones(csec_o));

  // Select the character for the current position in "HH:MM:SS.CC\r\n".
  always_comb begin
    char_mux = 8'h00;
    case (idx)
      4'd0:    char_mux = hour_t;
      4'd1:    char_mux = hour_o;
      4'd2:    char_mux = COLON;
      4'd3:    char_mux = min_t;
      4'd4:    char_mux = min_o;
      4'd5:    char_mux = COLON;
      4'd6:    char_mux = sec_t;
      4'd7:    char_mux = sec_o;
      4'd8:    char_mux = DOT;
      4'd9:    char_mux = csec_t;
      4'd10:   char_mux = csec_o;
      4'd11:   char_mux = CR;
      4'd12:   char_mux = LF;
      default: char_mux = 8'h00;
    endcase
  end

  // Next-state logic and the per-cycle control strobes of the byte handshake.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    start_c    = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (!tx_busy) begin
          start_c    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = START;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset drops the message immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Snapshot, byte index and the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
      snap_csec <= '0;
      idx       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (load) begin
        snap_hour <= i_hour;
        snap_min  <= i_min;
        snap_sec  <= i_sec;
        snap_csec <= i_csec;
        idx       <= '0;
      end else if (advance) begin
        idx <= idx + 4'd1;
      end
      busy_q <= (state_next != IDLE);
      done_q <= finish;
    end
  end

  // tx_start is gated by tx_busy in the same cycle so it can never overlap a busy uart_tx;
  // tx_data comes from registered snapshot and index and so stays put until tx_done.
  assign tx_start = start_c;
  assign tx_data  = (state == IDLE) ? 8'h00 : char_mux;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_time_sender.sv
// tb/tb_uart_time_sender.sv - randomized self-checking bench for uart_time_sender
module tb_uart_time_sender;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min_v = '0;
  logic [5:0] sec_v = '0;
  logic [6:0] csec_v = '0;
  logic       force_busy = 1'b0;

  logic       model_busy [2] = '{1'b0, 1'b0};
  logic       tx_done_r  [2] = '{1'b0, 1'b0};
  int         cnt        [2] = '{0, 0};
  logic       tx_busy_w  [2];
  logic       tx_start_w [2];
  logic [7:0] tx_data_w  [2];
  logic       busy_w     [2];
  logic       done_w     [2];

  logic [7:0] got_buf [2][512];
  int         got_n   [2] = '{0, 0};
  int         starts  [2] = '{0, 0};
  int         dones   [2] = '{0, 0};
  logic [7:0] last_data [2] = '{8'h00, 8'h00};

  int checks = 0;
  int errors = 0;

  assign tx_busy_w[0] = model_busy[0] | force_busy;
  assign tx_busy_w[1] = model_busy[1] | force_busy;

  uart_time_sender #(.LINE_END(1'b1)) u_full (
    .clk(clk), .rst(rst), .send(send),
    .i_hour(hour), .i_min(min_v), .i_sec(sec_v), .i_csec(csec_v),
    .tx_busy(tx_busy_w[0]), .tx_done(tx_done_r[0]),
    .tx_start(tx_start_w[0]), .tx_data(tx_data_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  uart_time_sender #(.LINE_END(1'b0)) u_short (
    .clk(clk), .rst(rst), .send(send),
    .i_hour(hour), .i_min(min_v), .i_sec(sec_v), .i_csec(csec_v),
    .tx_busy(tx_busy_w[1]), .tx_done(tx_done_r[1]),
    .tx_start(tx_start_w[1]), .tx_data(tx_data_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected byte at position idx of the line for the given field values.
  function automatic logic [7:0] ref_byte(input int idx, input int h, input int m,
                                          input int s, input int c);
    int f[4];
    int v;
    f[0] = h; f[1] = m; f[2] = s; f[3] = c;
    case (idx)
      2, 5: return 8'h3A;
      8:    return 8'h2E;
      11:   return 8'h0D;
      12:   return 8'h0A;
      default: begin
        v = f[idx / 3];
        if (v > 99) v = 99;
        if (idx % 3 == 0) return 8'(48 + v / 10);
        return 8'(48 + v % 10);
      end
    endcase
  endfunction

  // Behavioural uart_tx: busy for a random number of cycles, then a one-cycle done.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      tx_done_r[i] <= 1'b0;
      if (cnt[i] > 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1) begin
          model_busy[i] <= 1'b0;
          tx_done_r[i]  <= 1'b1;
        end
      end else if (tx_start_w[i]) begin
        model_busy[i] <= 1'b1;
        cnt[i]        <= int'($urandom_range(2, 6));
      end
    end
  end

  // Record every started byte and watch the handshake rules on both instances.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_start_w[i]) begin
        check("start_while_busy", 32'(tx_busy_w[i]), 32'h0);
        got_buf[i][got_n[i] % 512] = tx_data_w[i];
        got_n[i]++;
        starts[i]++;
        last_data[i] = tx_data_w[i];
      end else if (busy_w[i] && model_busy[i]) begin
        check("data_hold", 32'(tx_data_w[i]), 32'(last_data[i]));
      end
      if (done_w[i]) begin
        dones[i]++;
        check("busy_at_done", 32'(busy_w[i]), 32'h0);
      end
    end
  end

  task automatic run_msg(input int h, input int m, input int s, input int c,
                         input bit chg, input bit mid, input int hold);
    int b[2];
    int d[2];
    int st[2];
    int lens[2];
    lens[0] = 13;
    lens[1] = 11;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      b[i] = got_n[i];
      d[i] = dones[i];
      st[i] = starts[i];
    end
    if (hold > 0) force_busy = 1'b1;
    hour = 5'(h); min_v = 6'(m); sec_v = 6'(s); csec_v = 7'(c);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("busy_after_send_full", 32'(busy_w[0]), 32'h1);
    check("busy_after_send_short", 32'(busy_w[1]), 32'h1);
    if (hold == 0) check("first_start_n1", 32'(tx_start_w[0]), 32'h1);
    if (chg) begin
      hour = 5'd23; min_v = 6'd59; sec_v = 6'd59; csec_v = 7'd99;
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("no_start_while_held", 32'(starts[0] - st[0] + starts[1] - st[1]), 32'h0);
      force_busy = 1'b0;
    end
    if (mid) begin
      repeat (8) @(negedge clk);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
    end
    for (int k = 0; k < 4000 && !(dones[0] > d[0] && dones[1] > d[1]); k++) @(negedge clk);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("done_count", 32'(dones[i] - d[i]), 32'h1);
      check("start_count", 32'(starts[i] - st[i]), 32'(lens[i]));
      check("byte_count", 32'(got_n[i] - b[i]), 32'(lens[i]));
      check("busy_idle", 32'(busy_w[i]), 32'h0);
      for (int k = 0; k < lens[i]; k++)
        check($sformatf("byte%0d_inst%0d", k, i),
              32'(got_buf[i][(b[i] + k) % 512]), 32'(ref_byte(k, h, m, s, c)));
    end
  endtask

  initial begin
    int b0;
    int st0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start_w[0]), 32'h0);
    check("rst_tx_data", 32'(tx_data_w[0]), 32'h0);
    check("rst_busy", 32'(busy_w[0]), 32'h0);
    check("rst_done", 32'(done_w[0]), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_msg(12, 34, 56, 78, 1'b0, 1'b0, 0);
    run_msg(0, 0, 0, 5, 1'b0, 1'b0, 0);
    run_msg(12, 34, 56, 78, 1'b1, 1'b1, 0);
    run_msg(7, 8, 9, 10, 1'b0, 1'b0, 50);
    run_msg(0, 1, 2, 120, 1'b0, 1'b0, 0);
    run_msg(31, 59, 59, 127, 1'b0, 1'b0, 0);
    for (int r = 0; r < 6; r++)
      run_msg(int'($urandom_range(0, 31)), int'($urandom_range(0, 59)),
              int'($urandom_range(0, 59)), int'($urandom_range(0, 127)),
              1'($urandom_range(0, 1)), 1'b0, 0);

    // Reset in the middle of a message, after the fifth byte has started.
    @(negedge clk);
    b0 = got_n[0];
    hour = 5'd19; min_v = 6'd45; sec_v = 6'd30; csec_v = 7'd15;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int k = 0; k < 2000 && (got_n[0] - b0) < 5; k++) @(negedge clk);
    check("reached_fifth_byte", 32'(got_n[0] - b0), 32'h5);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_tx_start", 32'(tx_start_w[i]), 32'h0);
      check("midrst_tx_data", 32'(tx_data_w[i]), 32'h0);
      check("midrst_busy", 32'(busy_w[i]), 32'h0);
      check("midrst_done", 32'(done_w[i]), 32'h0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    st0 = starts[0] + starts[1];
    repeat (30) @(negedge clk);
    check("stray_done_no_start", 32'(starts[0] + starts[1] - st0), 32'h0);
    check("stray_done_idle_full", 32'(busy_w[0]), 32'h0);
    check("stray_done_idle_short", 32'(busy_w[1]), 32'h0);
    run_msg(21, 3, 47, 66, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_time_sender.md
# uart_time_sender

Transmit-side companion to the stopwatch UART controller. On a one-cycle `send` request it snapshots the current time and formats it as the ASCII line "HH:MM:SS.CC" plus optional CR LF. It then feeds the line byte by byte into the existing `uart_tx` through its start/busy/done handshake. It sits beside the receive path in the stopwatch/watch top level, sharing `clk`, `rst` and the `uart_tx` instance.

## Interface
- `LINE_END`, default 1: 1 appends CR (8'h0D) and LF (8'h0A), giving 13 bytes; 0 gives 11 bytes.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `send`  in  1  one-cycle request to transmit the current time.
- `i_hour`  in  5  hours, 0-23.
- `i_min`  in  6  minutes, 0-59.
- `i_sec`  in  6  seconds, 0-59.
- `i_csec`  in  7  centiseconds, 0-99.
- `tx_busy`  in  1  `uart_tx` busy.
- `tx_done`  in  1  `uart_tx` one-cycle byte-complete pulse.
- `tx_start`  out  1  one-cycle byte start to `uart_tx`.
- `tx_data`  out  8  byte to transmit.
- `busy`  out  1  message in progress.
- `done`  out  1  one-cycle pulse when the last byte completes.

## Operation
- Reset values: `tx_start`=0, `tx_data`=8'h00, `busy`=0, `done`=0, state IDLE, index 0, snapshot registers 0.
- **IDLE**
  - `send`=1: register all four time fields into the snapshot, set index=0, set `busy`, go to START.
  - `send` in any other state is ignored, with no queuing.
- **START**
  - While `tx_busy`=1, wait.
  - Otherwise drive `tx_data`=char[index], pulse `tx_start` for 1 cycle, go to WAIT.
- **WAIT**
  - Hold `tx_data` stable.
  - On `tx_done`: if index = MSG_LEN-1, pulse `done`, clear `busy`, go to IDLE. Else increment index and go to START.
- **Character map** (index 0..12): H1 H0 ':' M1 M0 ':' S1 S0 '.' C1 C0 CR LF.
  - Each digit is 8'h30 + BCD digit of the snapshot field.
  - MSG_LEN = 13 if `LINE_END`=1, else 11.
- **Field conversion**
  - tens = v/10, ones = v%10.
  - Any field value > 99 (reachable only on `i_csec`) saturates to "99".
  - Hour values 24-31 are sent as-is, e.g. 31 becomes "31".
- **Snapshot**: input changes after the `send` cycle never affect the message in flight.
- **Reset mid-message**: everything returns to reset values immediately. Any byte already inside `uart_tx` completes there independently. A `tx_done` arriving in IDLE is ignored.

## Timing
- `send` in cycle N:
  - `busy`=1 from N+1.
  - First `tx_start` in N+1 if `tx_busy`=0, otherwise the first cycle after `tx_busy` falls.
- Next `tx_start` comes no earlier than the cycle after the `tx_done` of the previous byte, and only when `tx_busy`=0.
- `tx_data` is valid the same cycle as `tx_start` and is held until the matching `tx_done`.
- `tx_done` of the last byte in cycle M:
  - `done`=1 in M+1 only.
  - `busy`=0 from M+1.
  - A new `send` is accepted from M+1.
- `tx_done` outside WAIT is ignored.
- `tx_start` is never asserted while `tx_busy`=1.

## Structure
- Shared package (`uart_pkg`) holds:
  - ASCII constants: ASCII_0 8'h30, COLON 8'h3A, DOT 8'h2E, CR 8'h0D, LF 8'h0A.
  - State encoding: IDLE/START/WAIT.
  - MSG_LEN_FULL=13 and MSG_LEN_SHORT=11.
- Sub-module `bin2ascii2`, instantiated 4×:
  - 7-bit binary in, two 8-bit ASCII digits out, with saturation at 99.
  - Purely combinational, fed from the snapshot registers.
- Top level: FSM, 4-bit index counter, character mux, output registers.

## Test plan
- `LINE_END`=1, 12/34/56/78, `send` pulse, behavioural `uart_tx` model → bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A in order, exactly 13 `tx_start` pulses, one `done`, `busy` low afterwards.
- `LINE_END`=0, 00/00/00/05 → 30 30 3A 30 30 3A 30 30 2E 30 35, then `done`; no 0D/0A.
- Change all inputs to 23/59/59/99 right after `send`; additionally pulse `send` mid-message → the original line is sent unchanged and only one message is produced.
- Hold `tx_busy`=1 for 50 cycles at `send` → no `tx_start` until `tx_busy` falls; `tx_start` never coincides with `tx_busy`=1.
- `i_csec`=120 → C1 C0 = 39 39; `i_hour`=0 → 30 30.
- Assert `rst` after the 5th byte → all outputs 0 in the same cycle. The next `send` restarts from byte 31/H1, and a stray `tx_done` in IDLE causes no output.
